mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction cache (read-only)
// and a data cache. Accesses are serialised through IDLE -> BUSY -> RESP; when
// both caches request in the same IDLE cycle the grant alternates round-robin.
// Every output is a register, so the memory side sees clean, glitch-free
// strobes and the caches see single-cycle Ready pulses.
//
// Handshake: a cache raises its Strobe with address/direction/data and keeps
// it high until it sees its Ready pulse (exactly one cycle). The arbiter
// samples requests only in IDLE; anything that changes on the request inputs
// after the grant edge is ignored until the access has completed. The memory
// sees MStrobe high for exactly MEM_LATENCY cycles and must present read data
// on MDataIn during the last of those cycles.

module mem_arbiter #(
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IStrobe,
    input  logic [31:0] IAddress,
    output logic [31:0] IDataIn,
    output logic        IReady,
    input  logic        DStrobe,
    input  logic        DRW,
    input  logic [31:0] DAddress,
    input  logic [31:0] DDataOut,
    output logic [31:0] DDataIn,
    output logic        DReady,
    output logic        MStrobe,
    output logic        MRW,
    output logic [31:0] MAddress,
    output logic [31:0] MDataOut,
    input  logic [31:0] MDataIn,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter is loaded with MEM_LATENCY-1 so that the BUSY cycle in which it
    // reads zero is the last cycle of the memory strobe.
    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    state_t     state;
    logic [3:0] count;
    logic       owner_i;   // 1: current access belongs to the I-side
    logic       prefer_i;  // 1: I-side wins the next simultaneous request
    logic       grant_i;

    assign dbg_state = state;

    // I-side wins when it is the only requester, or when both request and it
    // holds the round-robin preference.
    always_comb begin
        grant_i = IStrobe && (!DStrobe || prefer_i);
    end

    // Arbitration FSM with all memory and cache-facing outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 4'd0;
            owner_i  <= 1'b0;
            prefer_i <= 1'b0;
            MStrobe  <= 1'b0;
            MRW      <= 1'b0;
            MAddress <= 32'd0;
            MDataOut <= 32'd0;
            IReady   <= 1'b0;
            DReady   <= 1'b0;
            IDataIn  <= 32'd0;
            DDataIn  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (IStrobe || DStrobe) begin
                        owner_i  <= grant_i;
                        // Preference flips to the other side on every grant,
                        // including uncontested ones.
                        prefer_i <= !grant_i;
                        MStrobe  <= 1'b1;
                        count    <= LAT_M1;
                        state    <= BUSY;
                        if (grant_i) begin
                            MAddress <= IAddress;
                            MRW      <= 1'b0;
                            MDataOut <= 32'd0;
                        end else begin
                            MAddress <= DAddress;
                            MRW      <= DRW;
                            MDataOut <= DDataOut;
                        end
                    end
                end
                BUSY: begin
                    if (count == 4'd0) begin
                        MStrobe <= 1'b0;
                        state   <= RESP;
                        if (owner_i) begin
                            IReady  <= 1'b1;
                            IDataIn <= MDataIn;
                        end else begin
                            DReady <= 1'b1;
                            // A write leaves the last read value in place.
                            if (!MRW) begin
                                DDataIn <= MDataIn;
                            end
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    IReady <= 1'b0;
                    DReady <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Drivers push the expected
// sequence of memory accesses (order predicted by a round-robin model) into
// exp_q; a negedge monitor checks each memory strobe and each Ready pulse
// against the front of the queue. A second instance with MEM_LATENCY=1
// covers the shortest latency.

module tb_mem_arbiter;

    localparam int L = 4;
    localparam int W = 98;   // {side_i, rw, addr[31:0], wdata[31:0], rdata[31:0]}

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        IStrobe = 1'b0;
    logic [31:0] IAddress = 32'd0;
    logic [31:0] IDataIn;
    logic        IReady;
    logic        DStrobe = 1'b0;
    logic        DRW = 1'b0;
    logic [31:0] DAddress = 32'd0;
    logic [31:0] DDataOut = 32'd0;
    logic [31:0] DDataIn;
    logic        DReady;
    logic        MStrobe;
    logic        MRW;
    logic [31:0] MAddress;
    logic [31:0] MDataOut;
    logic [31:0] MDataIn = 32'd0;
    logic [1:0]  dbg_state;

    logic        u1_istrobe = 1'b0;
    logic [31:0] u1_iaddress = 32'd0;
    logic [31:0] u1_idatain;
    logic        u1_iready;
    logic [31:0] u1_ddatain;
    logic        u1_dready;
    logic        u1_mstrobe;
    logic        u1_mrw;
    logic [31:0] u1_maddress;
    logic [31:0] u1_mdataout;
    logic [31:0] u1_mdatain = 32'd0;
    logic [1:0]  u1_dbg_state;

    mem_arbiter #(.MEM_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .IStrobe(IStrobe), .IAddress(IAddress), .IDataIn(IDataIn), .IReady(IReady),
        .DStrobe(DStrobe), .DRW(DRW), .DAddress(DAddress), .DDataOut(DDataOut),
        .DDataIn(DDataIn), .DReady(DReady),
        .MStrobe(MStrobe), .MRW(MRW), .MAddress(MAddress), .MDataOut(MDataOut),
        .MDataIn(MDataIn), .dbg_state(dbg_state)
    );

    mem_arbiter #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .IStrobe(u1_istrobe), .IAddress(u1_iaddress), .IDataIn(u1_idatain), .IReady(u1_iready),
        .DStrobe(1'b0), .DRW(1'b0), .DAddress(32'd0), .DDataOut(32'd0),
        .DDataIn(u1_ddatain), .DReady(u1_dready),
        .MStrobe(u1_mstrobe), .MRW(u1_mrw), .MAddress(u1_maddress), .MDataOut(u1_mdataout),
        .MDataIn(u1_mdatain), .dbg_state(u1_dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string msg);
        n_checks++;
        n_errors++;
        $display("FAIL %s %s", name, msg);
    endtask

    // Memory contents as seen by the bench: one fixed word plus a hash.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [W-1:0] make_item(input logic side_i, input logic rw,
                                               input logic [31:0] addr, input logic [31:0] wdata);
        return {side_i, rw, addr, wdata, (rw ? 32'd0 : mem_f(addr))};
    endfunction

    // Reference model state
    logic [W-1:0] exp_q[$];
    logic         pref_i_m = 1'b0;
    logic [31:0]  last_i_m = 32'd0;
    logic [31:0]  last_d_m = 32'd0;

    // Monitor / scoreboard
    logic [W-1:0] cur;
    int           cnt = 0;
    logic         prev_ms = 1'b0;
    logic         prev_rdy = 1'b0;
    logic         rdy;

    always @(negedge clk) begin
        if (reset) begin
            cnt      = 0;
            prev_ms  = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            rdy = IReady || DReady;
            if (MStrobe && !prev_ms) begin
                cnt = 0;
                if (exp_q.size() == 0) begin
                    fail("unexpected_access", $sformatf("addr=%h", MAddress));
                    cur = '0;
                end else begin
                    cur = exp_q[0];
                    chk("access_addr", MAddress, cur[95:64]);
                    chk("access_rw", 32'(MRW), 32'(cur[96]));
                    if (cur[96]) chk("access_wdata", MDataOut, cur[63:32]);
                end
            end else if (MStrobe && prev_ms) begin
                chk("busy_addr_stable", MAddress, cur[95:64]);
                chk("busy_rw_stable", 32'(MRW), 32'(cur[96]));
            end
            if (MStrobe) cnt++;
            if (prev_ms && !MStrobe) chk("ready_after_strobe", 32'(rdy), 32'd1);
            if (rdy) begin
                chk("ready_exclusive", 32'(IReady & DReady), 32'd0);
                chk("strobe_cycles", 32'(cnt), 32'(L));
                chk("ready_one_cycle", 32'(prev_rdy), 32'd0);
                if (exp_q.size() == 0) begin
                    fail("unexpected_ready", $sformatf("i=%0d d=%0d", IReady, DReady));
                end else begin
                    cur = exp_q.pop_front();
                    chk("ready_side_i", 32'(IReady), 32'(cur[97]));
                    if (cur[97]) begin
                        chk("idata", IDataIn, cur[31:0]);
                        last_i_m = cur[31:0];
                        chk("ddata_hold", DDataIn, last_d_m);
                    end else if (cur[96]) begin
                        chk("ddata_after_write", DDataIn, last_d_m);
                        chk("idata_hold", IDataIn, last_i_m);
                    end else begin
                        chk("ddata", DDataIn, cur[31:0]);
                        last_d_m = cur[31:0];
                        chk("idata_hold", IDataIn, last_i_m);
                    end
                end
                cnt = 0;
            end
            prev_ms  = MStrobe;
            prev_rdy = rdy;
            // Read data is only valid in the last strobe cycle; garbage otherwise.
            MDataIn = (MStrobe && cnt == L) ? mem_f(MAddress) : $urandom;
        end
    end

    // Driver
    logic [W-1:0] pi_q[$];
    logic [W-1:0] pd_q[$];

    task automatic apply_i();
        if (pi_q.size() > 0) begin
            IStrobe  = 1'b1;
            IAddress = pi_q[0][95:64];
        end else begin
            IStrobe = 1'b0;
        end
    endtask

    task automatic apply_d();
        if (pd_q.size() > 0) begin
            DStrobe  = 1'b1;
            DRW      = pd_q[0][96];
            DAddress = pd_q[0][95:64];
            DDataOut = pd_q[0][63:32];
        end else begin
            DStrobe = 1'b0;
        end
    endtask

    // Raise both sides' first requests together and hold each strobe until
    // that side has been served for every queued item.
    task automatic run_round();
        logic [W-1:0] ti[$];
        logic [W-1:0] td[$];
        int k;
        ti = pi_q;
        td = pd_q;
        while (ti.size() > 0 || td.size() > 0) begin
            if (ti.size() > 0 && (td.size() == 0 || pref_i_m)) begin
                exp_q.push_back(ti.pop_front());
                pref_i_m = 1'b0;
            end else begin
                exp_q.push_back(td.pop_front());
                pref_i_m = 1'b1;
            end
        end
        @(negedge clk); #1;
        apply_i();
        apply_d();
        k = 0;
        while ((pi_q.size() > 0 || pd_q.size() > 0) && k < 200) begin
            @(negedge clk); #1;
            k++;
            if (IReady && pi_q.size() > 0) begin
                void'(pi_q.pop_front());
                apply_i();
            end
            if (DReady && pd_q.size() > 0) begin
                void'(pd_q.pop_front());
                apply_d();
            end
        end
        if (k >= 200) fail("round_timeout", "requests not served");
        pi_q.delete();
        pd_q.delete();
        IStrobe = 1'b0;
        DStrobe = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 1'b1;
        IStrobe = 1'b0;
        DStrobe = 1'b0;
        exp_q.delete();
        pref_i_m = 1'b0;
        last_i_m = 32'd0;
        last_d_m = 32'd0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int ni;
        int nd;
        int k;
        int ms_n;
        int ms_last;
        int rdy_at;

        // Reset state
        #1 reset = 1'b1;
        #2;
        chk("rst_mstrobe", 32'(MStrobe), 32'd0);
        chk("rst_mrw", 32'(MRW), 32'd0);
        chk("rst_maddress", MAddress, 32'd0);
        chk("rst_mdataout", MDataOut, 32'd0);
        chk("rst_iready", 32'(IReady), 32'd0);
        chk("rst_dready", 32'(DReady), 32'd0);
        chk("rst_idatain", IDataIn, 32'd0);
        chk("rst_ddatain", DDataIn, 32'd0);
        chk("rst_l1_mstrobe", 32'(u1_mstrobe), 32'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        // Single D read at 0x40
        pd_q.push_back(make_item(1'b0, 1'b0, 32'h40, 32'd0));
        run_round();
        chk("d_read_deadbeef", DDataIn, 32'hDEADBEEF);

        // D write at 0x80 leaves DDataIn untouched
        pd_q.push_back(make_item(1'b0, 1'b1, 32'h80, 32'h12345678));
        run_round();

        // After reset, both held: D, I, D, I
        do_reset();
        pi_q.push_back(make_item(1'b1, 1'b0, 32'h100, 32'd0));
        pi_q.push_back(make_item(1'b1, 1'b0, 32'h104, 32'd0));
        pd_q.push_back(make_item(1'b0, 1'b0, 32'h200, 32'd0));
        pd_q.push_back(make_item(1'b0, 1'b1, 32'h204, 32'hCAFEF00D));
        run_round();

        // DStrobe dropped (and address scrambled) in the 2nd BUSY cycle
        @(negedge clk); #1;
        exp_q.push_back(make_item(1'b0, 1'b0, 32'h300, 32'd0));
        pref_i_m = 1'b1;
        DStrobe = 1'b1; DRW = 1'b0; DAddress = 32'h300;
        repeat (2) @(negedge clk);
        #1 DStrobe = 1'b0; DAddress = $urandom; DRW = 1'b1;
        k = 0;
        while (exp_q.size() > 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) fail("drop_timeout", "no DReady after strobe drop");
        repeat (4) @(negedge clk);

        // Reset in the 2nd BUSY cycle abandons the access
        @(negedge clk); #1;
        exp_q.push_back(make_item(1'b0, 1'b0, 32'h400, 32'd0));
        DStrobe = 1'b1; DRW = 1'b0; DAddress = 32'h400;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_mstrobe", 32'(MStrobe), 32'd0);
        chk("rst_mid_dready", 32'(DReady), 32'd0);
        chk("rst_mid_ddatain", DDataIn, 32'd0);
        exp_q.delete();
        pref_i_m = 1'b0;
        last_i_m = 32'd0;
        last_d_m = 32'd0;
        // Strobe held during reset must not be granted
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_no_grant", 32'(MStrobe), 32'd0);
        end
        #1 DStrobe = 1'b0;
        @(negedge clk); #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 32'(MStrobe | DReady | IReady), 32'd0);
        pi_q.push_back(make_item(1'b1, 1'b0, 32'h500, 32'd0));
        pd_q.push_back(make_item(1'b0, 1'b0, 32'h600, 32'd0));
        run_round();

        // Randomised rounds
        for (int r = 0; r < 30; r++) begin
            ni = $urandom_range(0, 2);
            nd = $urandom_range(0, 2);
            if (ni == 0 && nd == 0) nd = 1;
            for (int j = 0; j < ni; j++)
                pi_q.push_back(make_item(1'b1, 1'b0, $urandom, 32'd0));
            for (int j = 0; j < nd; j++)
                pd_q.push_back(make_item(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom));
            run_round();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // MEM_LATENCY=1 instance: I read at 0x0
        @(negedge clk); #1;
        u1_istrobe = 1'b1;
        u1_iaddress = 32'h0;
        ms_n = 0;
        ms_last = -1;
        rdy_at = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (u1_mstrobe) begin
                ms_n++;
                ms_last = c;
                chk("l1_maddress", u1_maddress, 32'h0);
                chk("l1_mrw", 32'(u1_mrw), 32'd0);
            end
            if (u1_iready) begin
                if (rdy_at < 0) rdy_at = c;
                u1_istrobe = 1'b0;
            end
            u1_mdatain = u1_mstrobe ? mem_f(u1_maddress) : $urandom;
        end
        chk("l1_strobe_cycles", 32'(ms_n), 32'd1);
        chk("l1_ready_timing", 32'(rdy_at), 32'(ms_last + 1));
        chk("l1_idatain", u1_idatain, mem_f(32'h0));
        chk("l1_no_dready", 32'(u1_dready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

endmodule
